control_unit: RTL and testbench

Multicycle FSM that drives every select and write-enable consumed by the `cpu_MIPS` datapath. It decodes OPCODE/funct from the instruction register and sequences fetch, decode, execute, memory and write-back. It also handles the exception path for invalid instructions and arithmetic overflow. It is instantiated inside `cpu_MIPS` alongside the datapath muxes; its outputs connect to the datapath's existing control wires.

---
 rtl/cpu_ctrl_pkg.sv | 102 ++++++++++
 rtl/control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_control_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
// Holds the FSM state enum, opcode/funct constants, every datapath mux-select
// encoding (the datapath muxes import the same constants), the bundled control
// word struct and the DECODE dispatch helper.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_FETCH0, S_FETCH1, S_IRLD, S_DECODE,
        S_EXEC_R, S_WB_R, S_JR,
        S_EXEC_I, S_WB_I,
        S_ADDR, S_MRD0, S_MRD1, S_WB_LW, S_MWR,
        S_BRANCH, S_JUMP, S_LUI,
        S_EXC_OP, S_EXC_OVF, S_EXC_W, S_EXC_J
    } state_t;

    // Opcodes (IR[31:26]) and R-type functs (IR[5:0])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Mux-select encodings
    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_VEC    = 2'b10;
    localparam logic [1:0] EXC_VEC_OP  = 2'b00;  // vector 253
    localparam logic [1:0] EXC_VEC_OVF = 2'b01;  // vector 254
    localparam logic [2:0] SW_RT       = 3'b000;
    localparam logic [2:0] SW_RD       = 3'b001;
    localparam logic [2:0] SW_R29      = 3'b010;
    localparam logic [3:0] SD_ALUOUT   = 4'b0000;
    localparam logic [3:0] SD_LS       = 4'b0001;
    localparam logic [3:0] SD_SL16     = 4'b0010;
    localparam logic [3:0] SD_C227     = 4'b0011;
    localparam logic [1:0] ALUA_PC     = 2'b00;
    localparam logic [1:0] ALUA_A      = 2'b01;
    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_4      = 2'b01;
    localparam logic [1:0] ALUB_SE     = 2'b10;
    localparam logic [1:0] ALUB_SL2    = 2'b11;
    localparam logic [2:0] ALU_PASS    = 3'b000;
    localparam logic [2:0] ALU_ADD     = 3'b001;
    localparam logic [2:0] ALU_SUB     = 3'b010;
    localparam logic [2:0] ALU_AND     = 3'b011;
    localparam logic [2:0] ALU_CMP     = 3'b111;
    localparam logic [2:0] PCS_ALU     = 3'b000;
    localparam logic [2:0] PCS_ALUOUT  = 3'b001;
    localparam logic [2:0] PCS_JUMP    = 3'b010;
    localparam logic [2:0] PCS_LS      = 3'b011;
    localparam logic [1:0] LS_WORD     = 2'b00;
    localparam logic [1:0] LS_BYTE     = 2'b10;
    localparam logic [1:0] SS_WORD     = 2'b00;

    // Full control word driven by the FSM, one field per output port
    typedef struct packed {
        logic [1:0] iord;
        logic [1:0] excp;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic [2:0] src_write;
        logic [3:0] src_data;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [2:0] alu_ctl;
        logic       alu_out;
        logic [2:0] pc_src;
        logic       pc_write;
        logic       epc;
        logic [1:0] ls;
        logic [1:0] ss;
    } ctrl_t;

    // Where DECODE goes next; anything not recognised traps as invalid opcode.
    function automatic state_t decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        s = S_EXC_OP;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND) s = S_EXEC_R;
                else if (fn == FN_JR)                             s = S_JR;
            end
            OP_ADDI:         s = S_EXEC_I;
            OP_LW, OP_SW:    s = S_ADDR;
            OP_BEQ, OP_BNE:  s = S_BRANCH;
            OP_J:            s = S_JUMP;
            OP_LUI:          s = S_LUI;
            default:         s = S_EXC_OP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: multicycle MIPS control FSM.
// Sequences fetch / decode / execute / memory / write-back for the cpu_MIPS
// datapath and handles the invalid-instruction and overflow traps.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   opcode, funct     - IR[31:26], IR[5:0]
//   O, EQ             - ALU overflow and equality flags
//   iord .. ssControl - datapath mux selects and write enables (Moore,
//                       except pcWrite in BRANCH which follows EQ)
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       O,
    input  logic       EQ,
    output logic [1:0] iord,
    output logic [1:0] excpControl,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic       abWrite,
    output logic [2:0] srcWrite,
    output logic [3:0] srcData,
    output logic [1:0] aluScrcA,
    output logic [1:0] aluScrcB,
    output logic [2:0] aluControl,
    output logic       aluOutControl,
    output logic [2:0] pcSource,
    output logic       pcWrite,
    output logic       epcControl,
    output logic [1:0] lsControl,
    output logic [1:0] ssControl
);

    state_t state, next_state;
    // held: reset was sampled high at the last edge. The FSM sits in RST with
    // every output forced low until one edge sees reset low; RST then gets its
    // own cycle to initialise reg 29.
    logic   held;
    // Remembers which trap is in flight so EXC_W keeps the vector select stable
    // for the second cycle of the synchronous memory read.
    logic   exc_ovf_q;
    ctrl_t  c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            held      <= 1'b1;
            exc_ovf_q <= 1'b0;
        end else begin
            state <= next_state;
            held  <= 1'b0;
            if (state == S_EXC_OP)       exc_ovf_q <= 1'b0;
            else if (state == S_EXC_OVF) exc_ovf_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RST:     next_state = held ? S_RST : S_FETCH0;
            S_FETCH0:  next_state = S_FETCH1;
            S_FETCH1:  next_state = S_IRLD;
            S_IRLD:    next_state = S_DECODE;
            S_DECODE:  next_state = decode_dispatch(opcode, funct);
            // and cannot overflow; only add/sub trap
            S_EXEC_R:  next_state = (O && funct != FN_AND) ? S_EXC_OVF : S_WB_R;
            S_EXEC_I:  next_state = O ? S_EXC_OVF : S_WB_I;
            S_ADDR:    next_state = (opcode == OP_LW) ? S_MRD0 : S_MWR;
            S_MRD0:    next_state = S_MRD1;
            S_MRD1:    next_state = S_WB_LW;
            S_EXC_OP,
            S_EXC_OVF: next_state = S_EXC_W;
            S_EXC_W:   next_state = S_EXC_J;
            default:   next_state = S_FETCH0;  // all single-cycle tails
        endcase
    end

    always_comb begin
        c = '0;
        if (!held) begin
            case (state)
                S_RST: begin
                    c.src_write = SW_R29;
                    c.src_data  = SD_C227;
                    c.reg_write = 1'b1;
                end
                S_FETCH0: c.iord = IORD_PC;
                S_FETCH1: begin
                    c.alu_a    = ALUA_PC;
                    c.alu_b    = ALUB_4;
                    c.alu_ctl  = ALU_ADD;
                    c.pc_src   = PCS_ALU;
                    c.pc_write = 1'b1;
                end
                S_IRLD: c.ir_write = 1'b1;
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    c.ab_write = 1'b1;
                    c.alu_a    = ALUA_PC;
                    c.alu_b    = ALUB_SL2;
                    c.alu_ctl  = ALU_ADD;
                    c.alu_out  = 1'b1;
                end
                S_EXEC_R: begin
                    c.alu_a   = ALUA_A;
                    c.alu_b   = ALUB_B;
                    c.alu_ctl = (funct == FN_SUB) ? ALU_SUB :
                                (funct == FN_AND) ? ALU_AND : ALU_ADD;
                    c.alu_out = 1'b1;
                end
                S_WB_R: begin
                    c.src_write = SW_RD;
                    c.reg_write = 1'b1;
                end
                S_JR: begin
                    c.alu_a    = ALUA_A;
                    c.alu_ctl  = ALU_PASS;
                    c.pc_src   = PCS_ALU;
                    c.pc_write = 1'b1;
                end
                S_EXEC_I, S_ADDR: begin
                    c.alu_a   = ALUA_A;
                    c.alu_b   = ALUB_SE;
                    c.alu_ctl = ALU_ADD;
                    c.alu_out = 1'b1;
                end
                S_WB_I: begin
                    c.src_write = SW_RT;
                    c.reg_write = 1'b1;
                end
                S_MRD0, S_MRD1: c.iord = IORD_ALUOUT;
                S_WB_LW: begin
                    c.src_data  = SD_LS;
                    c.ls        = LS_WORD;
                    c.src_write = SW_RT;
                    c.reg_write = 1'b1;
                end
                S_MWR: begin
                    c.iord      = IORD_ALUOUT;
                    c.mem_write = 1'b1;
                    c.ss        = SS_WORD;
                end
                S_BRANCH: begin
                    c.alu_a    = ALUA_A;
                    c.alu_b    = ALUB_B;
                    c.alu_ctl  = ALU_CMP;
                    c.pc_src   = PCS_ALUOUT;
                    c.pc_write = (opcode == OP_BEQ) ? EQ : !EQ;
                end
                S_JUMP: begin
                    c.pc_src   = PCS_JUMP;
                    c.pc_write = 1'b1;
                end
                S_LUI: begin
                    c.src_data  = SD_SL16;
                    c.src_write = SW_RT;
                    c.reg_write = 1'b1;
                end
                S_EXC_OP, S_EXC_OVF: begin
                    // EPC <- PC - 4 while the vector byte address goes out
                    c.alu_a   = ALUA_PC;
                    c.alu_b   = ALUB_4;
                    c.alu_ctl = ALU_SUB;
                    c.epc     = 1'b1;
                    c.iord    = IORD_VEC;
                    c.excp    = (state == S_EXC_OVF) ? EXC_VEC_OVF : EXC_VEC_OP;
                end
                S_EXC_W: begin
                    c.iord = IORD_VEC;
                    c.excp = exc_ovf_q ? EXC_VEC_OVF : EXC_VEC_OP;
                end
                S_EXC_J: begin
                    c.ls       = LS_BYTE;
                    c.pc_src   = PCS_LS;
                    c.pc_write = 1'b1;
                end
                default: c = '0;
            endcase
        end
    end

    assign iord          = c.iord;
    assign excpControl   = c.excp;
    assign memWrite      = c.mem_write;
    assign irWrite       = c.ir_write;
    assign regWrite      = c.reg_write;
    assign abWrite       = c.ab_write;
    assign srcWrite      = c.src_write;
    assign srcData       = c.src_data;
    assign aluScrcA      = c.alu_a;
    assign aluScrcB      = c.alu_b;
    assign aluControl    = c.alu_ctl;
    assign aluOutControl = c.alu_out;
    assign pcSource      = c.pc_src;
    assign pcWrite       = c.pc_write;
    assign epcControl    = c.epc;
    assign lsControl     = c.ls;
    assign ssControl     = c.ss;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit.
// A per-instruction schedule of expected control words is built from the
// instruction semantics and compared cycle by cycle; a table of key cycles
// and hand-written reset/abort sequences cover the corner cases.
module tb_control_unit;

    typedef struct packed {
        logic [1:0] iord;
        logic [1:0] excp;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic [2:0] src_write;
        logic [3:0] src_data;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [2:0] alu_ctl;
        logic       alu_out;
        logic [2:0] pc_src;
        logic       pc_write;
        logic       epc;
        logic [1:0] ls;
        logic [1:0] ss;
    } cw_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       o;
        logic       eq;
        int         key;
        cw_t        key_out;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       O = 1'b0, EQ = 1'b0;
    logic [1:0] iord, excpControl, aluScrcA, aluScrcB, lsControl, ssControl;
    logic       memWrite, irWrite, regWrite, abWrite, aluOutControl, pcWrite, epcControl;
    logic [2:0] srcWrite, aluControl, pcSource;
    logic [3:0] srcData;

    int n_vec = 0;
    int n_bad = 0;
    cw_t exp_q[$];
    cw_t got;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .O(O), .EQ(EQ),
        .iord(iord), .excpControl(excpControl), .memWrite(memWrite), .irWrite(irWrite),
        .regWrite(regWrite), .abWrite(abWrite), .srcWrite(srcWrite), .srcData(srcData),
        .aluScrcA(aluScrcA), .aluScrcB(aluScrcB), .aluControl(aluControl),
        .aluOutControl(aluOutControl), .pcSource(pcSource), .pcWrite(pcWrite),
        .epcControl(epcControl), .lsControl(lsControl), .ssControl(ssControl)
    );

    assign got = '{iord, excpControl, memWrite, irWrite, regWrite, abWrite, srcWrite, srcData,
                   aluScrcA, aluScrcB, aluControl, aluOutControl, pcSource, pcWrite,
                   epcControl, lsControl, ssControl};

    task automatic check(input string name, input cw_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Trap tail: EPC capture + vector address, memory wait, PC <- vector byte
    function automatic void push_exc(input logic [1:0] vec);
        cw_t t;
        t = '0; t.alu_b = 2'b01; t.alu_ctl = 3'b010; t.epc = 1; t.iord = 2'b10; t.excp = vec;
        exp_q.push_back(t);
        t = '0; t.iord = 2'b10; t.excp = vec;
        exp_q.push_back(t);
        t = '0; t.ls = 2'b10; t.pc_src = 3'b011; t.pc_write = 1;
        exp_q.push_back(t);
    endfunction

    // Expected control word for every cycle of one instruction
    function automatic void plan(input logic [5:0] op, input logic [5:0] fn,
                                 input logic o, input logic eq);
        cw_t t;
        bit  r_alu, jr;
        exp_q.delete();
        t = '0; exp_q.push_back(t);                                       // fetch, addr=PC
        t = '0; t.alu_b = 2'b01; t.alu_ctl = 3'b001; t.pc_write = 1; exp_q.push_back(t);
        t = '0; t.ir_write = 1; exp_q.push_back(t);
        t = '0; t.ab_write = 1; t.alu_b = 2'b11; t.alu_ctl = 3'b001; t.alu_out = 1;
        exp_q.push_back(t);
        r_alu = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        jr    = (op == 6'h00) && (fn == 6'h08);
        if (r_alu) begin
            t = '0; t.alu_a = 2'b01; t.alu_out = 1;
            t.alu_ctl = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(t);
            if (o && fn != 6'h24) push_exc(2'b01);
            else begin t = '0; t.src_write = 3'b001; t.reg_write = 1; exp_q.push_back(t); end
        end else if (jr) begin
            t = '0; t.alu_a = 2'b01; t.pc_write = 1; exp_q.push_back(t);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            t = '0; t.alu_a = 2'b01; t.alu_b = 2'b10; t.alu_ctl = 3'b001; t.alu_out = 1;
            exp_q.push_back(t);
            if (op == 6'h08) begin
                if (o) push_exc(2'b01);
                else begin t = '0; t.reg_write = 1; exp_q.push_back(t); end
            end else if (op == 6'h23) begin
                t = '0; t.iord = 2'b01; exp_q.push_back(t); exp_q.push_back(t);
                t = '0; t.src_data = 4'b0001; t.reg_write = 1; exp_q.push_back(t);
            end else begin
                t = '0; t.iord = 2'b01; t.mem_write = 1; exp_q.push_back(t);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            t = '0; t.alu_a = 2'b01; t.alu_ctl = 3'b111; t.pc_src = 3'b001;
            t.pc_write = (op == 6'h04) ? eq : !eq;
            exp_q.push_back(t);
        end else if (op == 6'h02) begin
            t = '0; t.pc_src = 3'b010; t.pc_write = 1; exp_q.push_back(t);
        end else if (op == 6'h0F) begin
            t = '0; t.src_data = 4'b0010; t.reg_write = 1; exp_q.push_back(t);
        end else push_exc(2'b00);
    endfunction

    // Runs ncyc cycles of an instruction (all of it when ncyc < 0); checks the
    // schedule every cycle and the table record at cycle 'key'.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic o, input logic eq, input int ncyc,
                             input int key, input cw_t key_out);
        int n;
        opcode = op; funct = fn; O = o; EQ = eq;
        plan(op, fn, o, eq);
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, exp_q[i]);
            if (i == key) check({name, "_key"}, key_out);
        end
    endtask

    // Hold reset for n edges (outputs all zero), then release: one RST cycle
    task automatic do_reset(input int n);
        cw_t t;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset_zero", '0);
        end
        reset = 1'b0;
        @(negedge clk);
        t = '0; t.src_write = 3'b010; t.src_data = 4'b0011; t.reg_write = 1;
        check("rst_state", t);
    endtask

    vec_t vecs[16];

    initial begin
        cw_t k;
        logic [5:0] ops[9];
        logic [5:0] fns[5];
        ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h0F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h20};

        k = '0; k.reg_write = 1; k.src_write = 3'b001;
        vecs[0] = '{6'h00, 6'h20, 1'b0, 1'b0, 5, k};                   // add wb
        k = '0; k.alu_b = 2'b01; k.alu_ctl = 3'b001; k.pc_write = 1;
        vecs[1] = '{6'h00, 6'h20, 1'b0, 1'b1, 1, k};                   // pc+4
        k = '0; k.alu_b = 2'b01; k.alu_ctl = 3'b010; k.epc = 1; k.iord = 2'b10; k.excp = 2'b01;
        vecs[2] = '{6'h08, 6'h11, 1'b1, 1'b0, 5, k};                   // addi ovf
        vecs[9] = '{6'h00, 6'h22, 1'b1, 1'b0, 5, k};                   // sub ovf
        k = '0; k.ls = 2'b10; k.pc_src = 3'b011; k.pc_write = 1;
        vecs[3] = '{6'h08, 6'h00, 1'b1, 1'b1, 7, k};                   // trap jump
        k = '0; k.src_data = 4'b0001; k.reg_write = 1;
        vecs[4] = '{6'h23, 6'h00, 1'b0, 1'b0, 7, k};                   // lw wb
        k = '0; k.iord = 2'b01;
        vecs[5] = '{6'h23, 6'h00, 1'b1, 1'b0, 6, k};                   // lw addr hold
        k = '0; k.alu_a = 2'b01; k.alu_ctl = 3'b111; k.pc_src = 3'b001;
        vecs[6] = '{6'h04, 6'h00, 1'b0, 1'b0, 4, k};                   // beq not taken
        k.pc_write = 1;
        vecs[7] = '{6'h05, 6'h00, 1'b0, 1'b0, 4, k};                   // bne taken
        k = '0; k.iord = 2'b10;
        vecs[8] = '{6'h3F, 6'h00, 1'b0, 1'b0, 5, k};                   // bad op wait
        k = '0; k.reg_write = 1; k.src_write = 3'b001;
        vecs[10] = '{6'h00, 6'h24, 1'b1, 1'b0, 5, k};                  // and ignores O
        k = '0; k.alu_b = 2'b01; k.alu_ctl = 3'b010; k.epc = 1; k.iord = 2'b10;
        vecs[11] = '{6'h00, 6'h21, 1'b0, 1'b0, 4, k};                  // bad funct
        k = '0; k.pc_src = 3'b010; k.pc_write = 1;
        vecs[12] = '{6'h02, 6'h00, 1'b0, 1'b0, 4, k};                  // j
        k = '0; k.src_data = 4'b0010; k.reg_write = 1;
        vecs[13] = '{6'h0F, 6'h00, 1'b0, 1'b0, 4, k};                  // lui
        k = '0; k.alu_a = 2'b01; k.pc_write = 1;
        vecs[14] = '{6'h00, 6'h08, 1'b0, 1'b0, 4, k};                  // jr
        k = '0; k.iord = 2'b01; k.mem_write = 1;
        vecs[15] = '{6'h2B, 6'h00, 1'b0, 1'b0, 5, k};                  // sw

        do_reset(3);
        for (int i = 0; i < 16; i++)
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].o, vecs[i].eq,
                      -1, vecs[i].key, vecs[i].key_out);

        // Reset during EXC_W: no PC load may follow
        run_instr("exc_abort", 6'h3F, 6'h00, 1'b0, 1'b0, 6, -1, '0);
        do_reset(1);
        // Reset between the two lw address cycles: no register write afterwards
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, 6, -1, '0);
        do_reset(2);
        run_instr("post_abort", 6'h00, 6'h22, 1'b0, 1'b0, -1, -1, '0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr("rand", op, fn, 1'($urandom), 1'($urandom), -1, -1, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
